// File: rtl/encoder8_queue.sv
// encoder8_queue: sequential 8-to-3 encoder. Request lines accumulate in a
// pending register and are issued one binary index at a time over a
// valid/ready handshake, in fixed priority order (HIGH_FIRST).
// Build option ENCODER8_RR_EN: round-robin selection from a last-issued
// pointer replaces fixed priority, and HIGH_FIRST is ignored.
module encoder8_queue #(
  parameter int unsigned N_IN       = 8,
  parameter int unsigned CODE_W     = 3,
  parameter bit          HIGH_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_IN-1:0]   req_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic [N_IN-1:0]   pending_o,
  output logic              overflow_o,
  output logic              idle_o
);

  typedef enum logic {IDLE, VALID} state_t;

  state_t              state;
  logic [N_IN-1:0]     pending;
  logic [CODE_W-1:0]   sel_c;
  logic [N_IN-1:0]     clr_c;
  logic                load_c;

`ifdef ENCODER8_RR_EN
  logic [CODE_W-1:0]   rr_ptr;

  // Round-robin pick: first pending bit scanning upward from rr_ptr+1, wrapping
  always_comb begin
    logic [CODE_W-1:0] idx;
    sel_c = '0;
    idx   = '0;
    for (int i = int'(N_IN); i >= 1; i--) begin
      idx = rr_ptr + CODE_W'(i);
      if (pending[idx]) sel_c = idx;
    end
  end
`else
  // Fixed-priority pick over the registered pending vector only
  always_comb begin
    sel_c = '0;
    if (HIGH_FIRST) begin
      for (int i = 0; i < int'(N_IN); i++)
        if (pending[i]) sel_c = CODE_W'(i);
    end else begin
      for (int i = int'(N_IN) - 1; i >= 0; i--)
        if (pending[i]) sel_c = CODE_W'(i);
    end
  end
`endif

  // Load a new code from IDLE, or back-to-back when the current one is taken
  always_comb begin
    load_c = (pending != '0) && ((state == IDLE) || out_ready);
    clr_c  = load_c ? (N_IN'(1) << sel_c) : '0;
  end

  // State, pending register, handshake outputs and overflow pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pending    <= '0;
      out_valid  <= 1'b0;
      out_code   <= '0;
      overflow_o <= 1'b0;
`ifdef ENCODER8_RR_EN
      rr_ptr     <= CODE_W'(N_IN - 1);
`endif
    end else begin
      // Set wins over clear, so a re-request of the loading index stays queued
      pending    <= (pending & ~clr_c) | req_i;
      overflow_o <= |(req_i & pending & ~clr_c);
      case (state)
        IDLE: begin
          if (load_c) begin
            out_code  <= sel_c;
            out_valid <= 1'b1;
            state     <= VALID;
          end
        end
        VALID: begin
          if (load_c) begin
            out_code <= sel_c;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
`ifdef ENCODER8_RR_EN
      if (load_c) rr_ptr <= sel_c;
`endif
    end
  end

  assign pending_o = pending;
  assign idle_o    = (state == IDLE) && (pending == '0);

endmodule

// File: doc/encoder8_queue.md
Name: encoder8_queue

Overview:
- Sequential 8-to-3 encoder; the inverse of the 3-to-8 decoder.
- Collects one-hot or multi-hot request lines into a pending register.
- Emits one 3-bit binary index at a time, in priority order, over a valid/ready handshake.
- Sits upstream of decoder3-style consumers; a round trip through the decoder reproduces the serviced request line.

Parameters:
- N_IN, 8, number of request lines; fixed at 8 for this revision.
- CODE_W, 3, output index width; equals clog2(N_IN).
- HIGH_FIRST, 1, 1 = index 7 highest priority; 0 = index 0 highest priority.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_i  input  8  request lines; bit k high for a cycle requests index k
- out_valid  output  1  out_code holds a valid index
- out_ready  input  1  consumer accepts out_code
- out_code  output  3  binary index of the serviced request
- pending_o  output  8  current pending register, not yet issued
- overflow_o  output  1  one-cycle pulse: request on an already-pending bit
- idle_o  output  1  high when state is IDLE and pending_o is 0

Behaviour:
- Reset: rst_n low forces the following immediately, regardless of clk:
  - pending = 0, state = IDLE
  - out_valid = 0, out_code = 3'b000
  - overflow_o = 0, idle_o = 1
- Reset mid-transfer drops any in-flight code and all pending requests.
- Pending update per clk edge:
  - pending <= (pending & ~clr) | req_i
  - clr is the one-hot of the index loaded this cycle; otherwise 0.
  - Set wins: a req_i bit equal to the index being loaded stays pending and is not flagged.
- overflow_o <= |(req_i & pending & ~clr); registered, high for exactly one cycle per offending edge. The duplicate request is merged, not queued twice.
- Selection:
  - Operates on the registered pending vector only; req_i never bypasses to out_code.
  - HIGH_FIRST=1: highest set index. HIGH_FIRST=0: lowest set index.
- FSM states:
  - IDLE: out_valid = 0. If pending != 0, load out_code = sel, set clr = onehot(sel), go to VALID.
  - VALID: out_valid = 1; out_code stays stable while out_ready = 0.
    - On out_valid & out_ready with pending != 0: load the next sel that edge (back-to-back, no bubble), stay in VALID.
    - On out_valid & out_ready with pending = 0: go to IDLE; out_valid drops next cycle; out_code holds its last value.
- Latency: req_i high at edge k -> pending bit set after edge k -> out_valid high after edge k+1 (2 cycles).
- Sustained throughput: one code per cycle while out_ready = 1 and pending != 0.
- idle_o is combinational from registered state; it must not glitch on req_i.
- No combinational path from out_ready to out_valid or out_code.

Optional Feature:
- Macro: ENCODER8_RR_EN
- Defined:
  - Round-robin selection replaces fixed priority; HIGH_FIRST is ignored.
  - A 3-bit last-issued pointer resets to 7.
  - Next sel = first set pending bit scanning upward from pointer+1, with wrap-around from 7 to 0.
  - The pointer updates on every load.
- Undefined: fixed priority per HIGH_FIRST; no pointer register is present.

Test Plan:
- Reset, then a single pulse req_i=8'b0000_0100 with out_ready=1 -> out_valid high 2 cycles later for 1 cycle; out_code=3'd2; pending_o returns to 0; idle_o returns to 1.
- Exhaustive single-line: pulse each of bits 0..7 in turn, wait for idle -> out_code equals the bit index; feeding out_code into decoder3 gives z_k=1 only.
- Multi-hot req_i=8'hA5 in one cycle, HIGH_FIRST=1, out_ready=1 -> codes 7,5,2,0 on consecutive cycles, no bubbles, then IDLE.
- Backpressure: req_i=8'h81 with out_ready=0 for 5 cycles -> out_code=7 held stable with out_valid=1; release -> 7 accepted, then 0; pending_o=8'h01 during the stall.
- Overflow and simultaneity:
  - With bit 3 pending and not yet loaded, pulse req_i bit 3 again -> overflow_o high exactly one cycle; code 3 issued once.
  - Pulse bit 5 on the edge where 5 is loaded -> no overflow; code 5 issued twice.
- Reset mid-operation: assert rst_n low while out_valid=1 and pending_o=8'h0E -> outputs go to reset values immediately, before the next edge; after release, no stale code is issued.
- With ENCODER8_RR_EN defined: hold req_i=8'h11 continuously, out_ready=1 -> codes alternate 0,4,0,4; overflow_o pulses on every repeat.
